// File: rtl/hfrv_soc_glue.sv
// hfrv_soc_glue
//   Glue between the HF-RISCV core's unified memory bus and the verification
//   environment. Core accesses are decoded to on-chip RAM or to a small MMIO
//   block (UART TX, free-running cycle counter, simulation exit). Every UART
//   byte, bus error and the halt request are exposed on ports for the monitor.
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   cpu_addr    in   32  core byte address
//   cpu_wdata   in   32  core write data, lane-aligned
//   cpu_we      in   4   byte write strobes (lane 0 = bits 7:0)
//   cpu_access  in   1   access valid; write if any cpu_we bit set, else read
//   cpu_rdata   out  32  read data, one cycle after the read access
//   cpu_stall   out  1   high during reset and while halted
//   uart_valid  out  1   one-cycle pulse per UART byte
//   uart_data   out  8   last UART byte written
//   bus_err     out  1   one-cycle pulse on an unmapped access
//   halt        out  1   sticky, set by a write to the exit register
//   exit_code   out  32  value written to the exit register
module hfrv_soc_glue #(
    parameter logic [31:0] RAM_BASE   = 32'h4000_0000,
    parameter int unsigned RAM_WORDS  = 16384,
    parameter logic [31:0] UART_ADDR  = 32'hF000_00D0,
    parameter logic [31:0] CYCLE_ADDR = 32'hF000_0010,
    parameter logic [31:0] EXIT_ADDR  = 32'hE000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_we,
    input  logic        cpu_access,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        uart_valid,
    output logic [7:0]  uart_data,
    output logic        bus_err,
    output logic        halt,
    output logic [31:0] exit_code
);

    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0]   ram_r [RAM_WORDS];
    logic [31:0]   cycle_r;

    logic [31:0]   ram_off_s;
    logic          ram_hit_s;
    logic          uart_hit_s;
    logic          cycle_hit_s;
    logic          exit_hit_s;
    logic          unmapped_s;
    logic          rd_s;
    logic          wr_s;
    logic [AW-1:0] ram_idx_s;

    // Address decode and access qualification.
    always_comb begin
        // Offset compare covers the whole RAM window in one unsigned test,
        // addresses below RAM_BASE wrap to large values and miss.
        ram_off_s   = cpu_addr - RAM_BASE;
        ram_hit_s   = (ram_off_s < RAM_BYTES);
        uart_hit_s  = (cpu_addr == UART_ADDR);
        cycle_hit_s = (cpu_addr == CYCLE_ADDR);
        exit_hit_s  = (cpu_addr == EXIT_ADDR);
        unmapped_s  = ~(ram_hit_s | uart_hit_s | cycle_hit_s | exit_hit_s);
        ram_idx_s   = cpu_addr[AW+1:2];
        rd_s        = cpu_access & ~(|cpu_we);
        // Once halted, every write is dropped so RAM and exit_code freeze.
        wr_s        = cpu_access & (|cpu_we) & ~halt;
    end

    // RAM byte-lane writes; contents survive reset, a write under reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && wr_s && ram_hit_s) begin
            if (cpu_we[0]) ram_r[ram_idx_s][7:0]   <= cpu_wdata[7:0];
            if (cpu_we[1]) ram_r[ram_idx_s][15:8]  <= cpu_wdata[15:8];
            if (cpu_we[2]) ram_r[ram_idx_s][23:16] <= cpu_wdata[23:16];
            if (cpu_we[3]) ram_r[ram_idx_s][31:24] <= cpu_wdata[31:24];
        end
    end

    // Read data register: updated only on reads, holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata <= 32'h0000_0000;
        end else if (rd_s) begin
            if (ram_hit_s) begin
                cpu_rdata <= ram_r[ram_idx_s];
            end else if (cycle_hit_s) begin
                cpu_rdata <= cycle_r;
            end else begin
                cpu_rdata <= 32'h0000_0000;
            end
        end
    end

    // Free-running cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_r <= 32'h0000_0000;
        end else begin
            cycle_r <= cycle_r + 32'h0000_0001;
        end
    end

    // UART transmit pulse and held byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_valid <= 1'b0;
            uart_data  <= 8'h00;
        end else begin
            uart_valid <= wr_s & uart_hit_s;
            if (wr_s && uart_hit_s) begin
                uart_data <= cpu_wdata[7:0];
            end
        end
    end

    // Bus error pulse for any access that hits no region.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= cpu_access & unmapped_s;
        end
    end

    // Sticky halt, exit code capture and core stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            halt      <= 1'b0;
            exit_code <= 32'h0000_0000;
            cpu_stall <= 1'b1;
        end else begin
            if (wr_s && exit_hit_s) begin
                halt      <= 1'b1;
                exit_code <= cpu_wdata;
            end
            // Stall rises in the same cycle halt does.
            cpu_stall <= halt | (wr_s & exit_hit_s);
        end
    end

endmodule

// File: tb/tb_hfrv_soc_glue.sv
// Testbench for hfrv_soc_glue: a table of directed vectors with hand-derived
// expected outputs, a cycle-counter sequence, and a randomized phase checked
// against a behavioural model of the memory map.
module tb_hfrv_soc_glue;

    localparam logic [31:0] RAM_BASE   = 32'h4000_0000;
    localparam logic [31:0] RAM_END    = 32'h4001_0000;
    localparam logic [31:0] UART_ADDR  = 32'hF000_00D0;
    localparam logic [31:0] CYCLE_ADDR = 32'hF000_0010;
    localparam logic [31:0] EXIT_ADDR  = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_we;
    logic        cpu_access;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        uart_valid;
    logic [7:0]  uart_data;
    logic        bus_err;
    logic        halt;
    logic [31:0] exit_code;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hfrv_soc_glue dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_access (cpu_access),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .bus_err    (bus_err),
        .halt       (halt),
        .exit_code  (exit_code)
    );

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic        acc;
        logic [31:0] e_rdata;
        logic        e_uv;
        logic [7:0]  e_ud;
        logic        e_berr;
        logic        e_halt;
        logic [31:0] e_code;
        logic        e_stall;
    } vec_t;

    vec_t vq[$];

    // Behavioural model state: outputs, cycles since reset, RAM window words.
    logic [31:0] m_rdata, m_code;
    logic        m_uv, m_berr, m_halt, m_stall;
    logic [7:0]  m_ud;
    logic [31:0] m_cnt;
    logic [31:0] mword [16];

    function automatic vec_t mk(input logic rst, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] we, input logic acc, input logic [31:0] e_rdata,
                                input logic e_uv, input logic [7:0] e_ud, input logic e_berr,
                                input logic e_halt, input logic [31:0] e_code, input logic e_stall);
        vec_t v;
        v.rst = rst; v.addr = addr; v.wdata = wdata; v.we = we; v.acc = acc;
        v.e_rdata = e_rdata; v.e_uv = e_uv; v.e_ud = e_ud; v.e_berr = e_berr;
        v.e_halt = e_halt; v.e_code = e_code; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e_rdata, input logic e_uv,
                              input logic [7:0] e_ud, input logic e_berr, input logic e_halt,
                              input logic [31:0] e_code, input logic e_stall);
        chk($sformatf("%s.rdata", tag), cpu_rdata, e_rdata);
        chk($sformatf("%s.uart_valid", tag), {31'd0, uart_valid}, {31'd0, e_uv});
        chk($sformatf("%s.uart_data", tag), {24'd0, uart_data}, {24'd0, e_ud});
        chk($sformatf("%s.bus_err", tag), {31'd0, bus_err}, {31'd0, e_berr});
        chk($sformatf("%s.halt", tag), {31'd0, halt}, {31'd0, e_halt});
        chk($sformatf("%s.exit_code", tag), exit_code, e_code);
        chk($sformatf("%s.stall", tag), {31'd0, cpu_stall}, {31'd0, e_stall});
    endtask

    // Apply the memory-map rules to the inputs seen at this rising edge.
    task automatic model_edge();
        int unsigned idx;
        logic wr;
        if (reset) begin
            m_rdata = 32'h0; m_uv = 1'b0; m_ud = 8'h00; m_berr = 1'b0;
            m_halt = 1'b0; m_code = 32'h0; m_stall = 1'b1; m_cnt = 32'h0;
        end else begin
            wr = cpu_access && (cpu_we != 4'h0);
            m_uv = 1'b0;
            m_berr = 1'b0;
            if (cpu_access) begin
                if (cpu_addr >= RAM_BASE && cpu_addr < RAM_END) begin
                    idx = (cpu_addr - RAM_BASE) / 4;
                    if (!wr) begin
                        m_rdata = (idx < 16) ? mword[idx] : 32'h0;
                    end else if (!m_halt && idx < 16) begin
                        for (int b = 0; b < 4; b++)
                            if (cpu_we[b]) mword[idx][8*b +: 8] = cpu_wdata[8*b +: 8];
                    end
                end else if (cpu_addr == UART_ADDR) begin
                    if (!wr) m_rdata = 32'h0;
                    else if (!m_halt) begin m_uv = 1'b1; m_ud = cpu_wdata[7:0]; end
                end else if (cpu_addr == CYCLE_ADDR) begin
                    if (!wr) m_rdata = m_cnt;
                end else if (cpu_addr == EXIT_ADDR) begin
                    if (!wr) m_rdata = 32'h0;
                    else if (!m_halt) begin m_halt = 1'b1; m_code = cpu_wdata; end
                end else begin
                    m_berr = 1'b1;
                    if (!wr) m_rdata = 32'h0;
                end
            end
            m_stall = m_halt;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    // One bus cycle: drive at the falling edge, clock, return at the next falling edge.
    task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w, input logic acc);
        reset = r; cpu_addr = a; cpu_wdata = d; cpu_we = w; cpu_access = acc;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a_cnt, b_cnt;
        logic [31:0] addr;
        logic [3:0]  we;
        logic        rst, acc;
        int          c;

        reset = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_we = 4'h0; cpu_access = 1'b0;
        dut.ram_r[16383] = 32'hCAFE_F00D;

        //            rst   addr           wdata          we     acc   rdata          uv    ud     berr  halt  code           stall
        vq.push_back(mk(1'b1, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         1'b1));
        vq.push_back(mk(1'b1, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         1'b1));
        vq.push_back(mk(1'b0, 32'h4000_0008, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0,         1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h4000_0008, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h4000_0008, 32'h0000_00AA, 4'h1, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h4000_0008, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEAA, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, UART_ADDR,     32'h0000_0048, 4'h1, 1'b1, 32'hDEAD_BEAA, 1'b1, 8'h48, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, UART_ADDR,     32'h0000_0069, 4'h1, 1'b1, 32'hDEAD_BEAA, 1'b1, 8'h69, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'hDEAD_BEAA, 1'b0, 8'h69, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h1000_0000, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0, 8'h69, 1'b1, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h4000_0008, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEAA, 1'b0, 8'h69, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, UART_ADDR,     32'h0,         4'h0, 1'b1, 32'h0,         1'b0, 8'h69, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h4000_000B, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEAA, 1'b0, 8'h69, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h1000_0004, 32'h1234_5678, 4'hF, 1'b1, 32'hDEAD_BEAA, 1'b0, 8'h69, 1'b1, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h4001_0000, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0, 8'h69, 1'b1, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h3FFF_FFFC, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0, 8'h69, 1'b1, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h4000_FFFC, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 8'h69, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, CYCLE_ADDR,    32'h0,         4'hF, 1'b1, 32'hCAFE_F00D, 1'b0, 8'h69, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, CYCLE_ADDR,    32'h0,         4'h0, 1'b1, 32'h0000_0010, 1'b0, 8'h69, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, EXIT_ADDR,     32'h0000_002A, 4'hF, 1'b1, 32'h0000_0010, 1'b0, 8'h69, 1'b0, 1'b1, 32'h0000_002A, 1'b1));
        vq.push_back(mk(1'b0, 32'h4000_0008, 32'h0,         4'hF, 1'b1, 32'h0000_0010, 1'b0, 8'h69, 1'b0, 1'b1, 32'h0000_002A, 1'b1));
        vq.push_back(mk(1'b0, EXIT_ADDR,     32'h0000_0055, 4'hF, 1'b1, 32'h0000_0010, 1'b0, 8'h69, 1'b0, 1'b1, 32'h0000_002A, 1'b1));
        vq.push_back(mk(1'b0, 32'h4000_0008, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEAA, 1'b0, 8'h69, 1'b0, 1'b1, 32'h0000_002A, 1'b1));
        vq.push_back(mk(1'b0, UART_ADDR,     32'h0000_0021, 4'h1, 1'b1, 32'hDEAD_BEAA, 1'b0, 8'h69, 1'b0, 1'b1, 32'h0000_002A, 1'b1));
        vq.push_back(mk(1'b1, UART_ADDR,     32'h0000_0033, 4'h1, 1'b1, 32'h0,         1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         1'b1));
        vq.push_back(mk(1'b1, UART_ADDR,     32'h0000_0033, 4'h1, 1'b1, 32'h0,         1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         1'b1));
        vq.push_back(mk(1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b0, 32'h4000_0008, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEAA, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         1'b0));
        vq.push_back(mk(1'b1, 32'h4000_0008, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0,         1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         1'b1));
        vq.push_back(mk(1'b0, 32'h4000_0008, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEAA, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,         1'b0));

        foreach (vq[i]) begin
            cyc(vq[i].rst, vq[i].addr, vq[i].wdata, vq[i].we, vq[i].acc);
            check_outs($sformatf("vec%0d", i), vq[i].e_rdata, vq[i].e_uv, vq[i].e_ud,
                       vq[i].e_berr, vq[i].e_halt, vq[i].e_code, vq[i].e_stall);
        end

        // Cycle counter: reads ten cycles apart after reset.
        cyc(1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        cyc(1'b0, CYCLE_ADDR, 32'h0, 4'h0, 1'b1);
        a_cnt = cpu_rdata;
        for (int i = 0; i < 9; i++) cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        cyc(1'b0, CYCLE_ADDR, 32'h0, 4'h0, 1'b1);
        b_cnt = cpu_rdata;
        chk("cycle_at_10", a_cnt, 32'd10);
        chk("cycle_at_20", b_cnt, 32'd20);
        chk("cycle_delta", b_cnt - a_cnt, 32'd10);

        // Randomized phase against the behavioural model.
        cyc(1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            mword[i] = $urandom;
            dut.ram_r[i] = mword[i];
        end
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 99) < 3);
            acc = 1'b1;
            we  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            c   = $urandom_range(0, 9);
            if (c <= 4) begin
                addr = RAM_BASE + 32'($urandom_range(0, 63));
            end else if (c == 5) begin
                addr = UART_ADDR;
            end else if (c == 6) begin
                addr = CYCLE_ADDR;
            end else if (c == 7) begin
                case ($urandom_range(0, 3))
                    0:       addr = 32'h1000_0000;
                    1:       addr = RAM_BASE - 32'd4;
                    2:       addr = RAM_END;
                    default: addr = {4'h2, 28'($urandom)};
                endcase
            end else if (c == 8) begin
                if ($urandom_range(0, 7) == 0) begin
                    addr = EXIT_ADDR;
                    we   = 4'hF;
                end else begin
                    addr = RAM_BASE + 32'($urandom_range(0, 63));
                    we   = 4'h0;
                end
            end else begin
                addr = RAM_BASE + 32'($urandom_range(0, 63));
                acc  = 1'b0;
            end
            cyc(rst, addr, $urandom, we, acc);
            check_outs($sformatf("rand%0d", n), m_rdata, m_uv, m_ud, m_berr, m_halt, m_code, m_stall);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
